// File: rtl/result_tx_sequencer.sv
// result_tx_sequencer: sends the BIP accumulator over uart_tx, LSB byte first, one frame per trigger.
// Optional TX_HEADER_EN macro prefixes every frame with HDR_BYTE.
`default_nettype none

module result_tx_sequencer #(
  parameter int          NBITS_D  = 16,
  parameter int          DBIT     = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic [NBITS_D-1:0] i_acc,
  input  logic               i_send,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_drop
);

  localparam int NBYTES = (NBITS_D + DBIT - 1) / DBIT;
`ifdef TX_HEADER_EN
  localparam int HDRN   = 1;
`else
  localparam int HDRN   = 0;
`endif
  localparam int NFRAME = NBYTES + HDRN;
  localparam int SHW    = NFRAME * DBIT;
  localparam int IDXW   = $clog2(NFRAME + 1);
  localparam logic [DBIT-1:0] HDR_W = DBIT'(HDR_BYTE);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, FINISH} state_t;

  state_t            state_q;
  logic [SHW-1:0]    shift_q;
  logic [IDXW-1:0]   idx_q;
  logic              pend_q;
  logic              halt_q;
  logic              send_q;
  logic              tx_start_q;
  logic [DBIT-1:0]   data_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              drop_q;

  logic                       trig;
  logic [NBYTES*DBIT-1:0]     acc_ext;
  logic [(NBYTES+1)*DBIT-1:0] load_full_d;
  logic [SHW-1:0]             load_d;
  logic [SHW-1:0]             shift_d;

  assign trig    = (i_halt & ~halt_q) | (i_send & ~send_q);
  assign acc_ext = (NBYTES*DBIT)'(i_acc);
  // Header sits in the low byte; without the header it is shifted out at elaboration.
  assign load_full_d = {acc_ext, HDR_W};
  assign load_d      = SHW'(load_full_d >> ((1 - HDRN) * DBIT));
  assign shift_d     = shift_q >> DBIT;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      halt_q       <= 1'b0;
      send_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      halt_q       <= i_halt;
      send_q       <= i_send;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (trig || pend_q) begin
            shift_q    <= load_d;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            data_q     <= load_d[DBIT-1:0];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            if (idx_q == IDXW'(NFRAME - 1)) begin
              frame_done_q <= 1'b1;
              state_q      <= FINISH;
            end else begin
              shift_q    <= shift_d;
              idx_q      <= idx_q + IDXW'(1);
              data_q     <= shift_d[DBIT-1:0];
              tx_start_q <= 1'b1;
              state_q    <= START;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A trigger during a frame is buffered once; a second one is discarded.
      if (state_q != IDLE && trig) begin
        if (pend_q) begin
          drop_q <= 1'b1;
        end else begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_data       = data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_drop       = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_result_tx_sequencer.sv
// Randomized self-checking bench for result_tx_sequencer against a frame-level reference model.
`default_nettype none

module tb_result_tx_sequencer;

`ifdef TX_HEADER_EN
  localparam int NF = 3;
`else
  localparam int NF = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        send;
  logic        done;
  logic [15:0] acc;
  logic        tx_start;
  logic [7:0]  data;
  logic        busy;
  logic        fdone;
  logic        drop;

  result_tx_sequencer #(.NBITS_D(16), .DBIT(8), .HDR_BYTE(8'hA5)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_halt(halt), .i_acc(acc), .i_send(send),
    .i_tx_done(done), .o_tx_start(tx_start), .o_data(data), .o_busy(busy),
    .o_frame_done(fdone), .o_drop(drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: frame bytes still to send, plus handshake flags
  logic [7:0] m_q[$];
  logic [7:0] m_data;
  bit m_busy, m_in_start, m_fin, m_pend, m_prev_h, m_prev_s;
  bit e_start, e_fdone, e_drop;

  // UART responder
  int r_cnt;
  int r_fixed;
  bit r_fresh;
  bit r_spur;

  // observation logs
  int n_start, n_drop, n_fdone;
  logic [7:0] obs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data = 8'h00; m_busy = 0; m_in_start = 0; m_fin = 0; m_pend = 0;
    m_prev_h = 0; m_prev_s = 0; e_start = 0; e_fdone = 0; e_drop = 0;
    r_cnt = 0; r_fresh = 0;
  endtask

  task automatic model_step(input bit h, input bit s, input bit d, input logic [15:0] a);
    bit trig;
    trig = (h & ~m_prev_h) | (s & ~m_prev_s);
    m_prev_h = h; m_prev_s = s;
    e_start = 0; e_fdone = 0; e_drop = 0;
    if (!m_busy) begin
      if (trig || m_pend) begin
        m_q.delete();
`ifdef TX_HEADER_EN
        m_q.push_back(8'hA5);
`endif
        m_q.push_back(a[7:0]);
        m_q.push_back(a[15:8]);
        m_pend  = 0;
        m_data  = m_q.pop_front();
        e_start = 1;
        m_busy  = 1;
      end
    end else begin
      if (trig) begin
        if (m_pend) e_drop = 1;
        else        m_pend = 1;
      end
      if (m_fin) begin
        m_fin = 0; m_busy = 0;
      end else if (!m_in_start && d) begin
        if (m_q.size() > 0) begin
          m_data = m_q.pop_front(); e_start = 1;
        end else begin
          m_fin = 1; e_fdone = 1;
        end
      end
    end
    m_in_start = e_start;
    if (e_start) begin
      r_cnt   = (r_fixed > 0) ? r_fixed : int'($urandom_range(2, 20));
      r_fresh = 1;
    end
  endtask

  task automatic tick();
    bit d;
    check_eq("tx_start", {31'b0, tx_start}, {31'b0, e_start});
    check_eq("data", {24'b0, data}, {24'b0, m_data});
    check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
    check_eq("frame_done", {31'b0, fdone}, {31'b0, e_fdone});
    check_eq("drop", {31'b0, drop}, {31'b0, e_drop});
    if (tx_start) begin n_start++; obs.push_back(data); end
    if (drop)  n_drop++;
    if (fdone) n_fdone++;
    d = 0;
    if (r_cnt > 0) begin
      r_cnt--;
      if (r_cnt == 0) d = 1;
    end
    if (r_fresh && r_spur && $urandom_range(0, 3) == 0) d = 1;
    r_fresh = 0;
    done = d;
    if (!rst_n) model_reset();
    else        model_step(halt, send, d, acc);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    n_start = 0; n_drop = 0; n_fdone = 0; obs.delete();
  endtask

  task automatic run_until_fdone(input int target, input int budget);
    int i = 0;
    while (n_fdone < target && i < budget) begin
      tick();
      i++;
    end
    check_eq("frame_done_timeout", n_fdone, target);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] exp[$];
    exp.delete();
`ifdef TX_HEADER_EN
    exp.push_back(8'hA5);
`endif
    exp.push_back(b0);
    exp.push_back(b1);
    check_eq({tag, "_nbytes"}, obs.size(), exp.size());
    if (obs.size() == exp.size()) begin
      for (int i = 0; i < exp.size(); i++)
        check_eq({tag, "_byte"}, {24'b0, obs[i]}, {24'b0, exp[i]});
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; halt = 0; send = 0; done = 0; acc = '0;
    r_fixed = 20; r_spur = 0;
    model_reset();
    clear_logs();
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // single frame from halt rise
    acc = 16'h1234; clear_logs();
    halt = 1;
    run_until_fdone(1, 200);
    repeat (3) tick();
    check_eq("t1_starts", n_start, NF);
    check_frame("t1", 8'h34, 8'h12);
    check_eq("t1_busy_after", {31'b0, busy}, 32'd0);

    // held halt never retriggers
    repeat (500) tick();
    check_eq("t2_starts", n_start, NF);

    // pending then drop
    clear_logs();
    halt = 0; repeat (3) tick();
    halt = 1; repeat (5) tick();
    send = 1; repeat (3) tick();
    halt = 0; tick();
    halt = 1;
    run_until_fdone(2, 400);
    repeat (4) tick();
    check_eq("t3_starts", n_start, 2 * NF);
    check_eq("t3_drops", n_drop, 1);
    check_eq("t3_fdone", n_fdone, 2);

    // simultaneous halt and send rise
    halt = 0; send = 0; repeat (5) tick();
    acc = 16'hBEEF; clear_logs();
    halt = 1; send = 1;
    run_until_fdone(1, 200);
    repeat (3) tick();
    check_frame("t4", 8'hEF, 8'hBE);
    check_eq("t4_drops", n_drop, 0);

    // async reset mid-frame
    halt = 0; send = 0; repeat (3) tick();
    acc = 16'h1234; clear_logs();
    halt = 1; repeat (8) tick();
    rst_n = 0;
    #1;
    check_eq("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check_eq("rst_data", {24'b0, data}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_frame_done", {31'b0, fdone}, 32'd0);
    check_eq("rst_drop", {31'b0, drop}, 32'd0);
    model_reset();
    halt = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();
    acc = 16'h00FF; clear_logs();
    halt = 1;
    run_until_fdone(1, 200);
    repeat (3) tick();
    check_frame("t5", 8'hFF, 8'h00);
    check_eq("t5_fdone", n_fdone, 1);

    // randomized traffic with random UART latency and stray done pulses
    r_fixed = 0; r_spur = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) halt = ~halt;
      if ($urandom_range(0, 29) == 0) send = ~send;
      acc = 16'($urandom);
      tick();
    end
    halt = 0; send = 0;
    repeat (150) tick();
    check_eq("drain_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
Sequences transmission of the BIP accumulator result over the shared uart_tx instance, one DBIT-wide byte at a time, LSB byte first. It sits between bip (o_Halt/o_ACC) and uart_tx (i_tx_start/i_din/o_tx_done) in the top level and owns the start/done handshake. Frames are triggered by a halt rising edge or a manual send request. Exactly one frame is sent per trigger, with one-deep pending buffering.

Parameters:
NBITS_D, 16, accumulator width in bits.
DBIT, 8, UART data width in bits; must match uart_tx DBIT.
NBYTES, (NBITS_D+DBIT-1)/DBIT, localparam; bytes per frame (2 at defaults).
HDR_BYTE, 8'hA5, sync byte value; used only when TX_HEADER_EN is defined.

Ports:
i_clk  input  1  system clock (clk_out1 domain).
i_reset  input  1  asynchronous, active-low reset.
i_halt  input  1  bip halt level.
i_acc  input  NBITS_D  bip accumulator; sampled on trigger.
i_send  input  1  manual send request, level; rising edge triggers.
i_tx_done  input  1  uart_tx one-cycle done pulse.
o_tx_start  output  1  one-cycle start pulse to uart_tx.
o_data  output  DBIT  byte to uart_tx; held stable from start until next byte is loaded.
o_busy  output  1  high while a frame is in progress.
o_frame_done  output  1  one-cycle pulse after the last byte's done.
o_drop  output  1  one-cycle pulse when a trigger is discarded.

Behaviour:
- Reset (i_reset=0, async): state=IDLE; o_tx_start=0, o_data=0, o_busy=0, o_frame_done=0, o_drop=0; pending flag and edge-detect registers cleared (halt_d=0, send_d=0). Reset mid-frame abandons the frame. No o_frame_done is issued.
- Trigger = (i_halt & ~halt_d) | (i_send & ~send_d), using registered delays. A halt held high never retriggers. Simultaneous halt and send rises count as a single trigger.
- States: IDLE, START, WAIT_DONE, FINISH.
- IDLE: on trigger, or with pending=1, capture i_acc into shift_reg (zero-extended to NBYTES*DBIT), load byte index idx=0, clear pending, go to START. If the trigger came from pending, capture i_acc at that cycle.
- START: o_tx_start=1 for exactly this cycle. o_data=shift_reg[DBIT-1:0], registered on entry. o_busy=1. Next state is WAIT_DONE. Latency is trigger-sampling edge to o_tx_start high = 1 clock.
- WAIT_DONE: o_tx_start=0; wait for i_tx_done. Any i_tx_done seen in START is ignored.
  - On done with idx<NBYTES-1: shift_reg >>= DBIT, idx++, go to START.
  - On done with idx==NBYTES-1: go to FINISH.
  - No timeout; waits indefinitely.
- FINISH: o_frame_done=1 for one cycle, o_busy=0 next cycle, return to IDLE. If pending=1, the next frame's START follows after IDLE (a 2-cycle gap).
- Trigger while busy (START/WAIT_DONE/FINISH): if pending=0, set pending=1. If pending=1 already, pulse o_drop for 1 cycle and discard.
- Non-multiple widths: the top byte is zero-padded in its MSBs (e.g., NBITS_D=12 sends acc[7:0] then {4'b0, acc[11:8]}).
- idx width is $clog2(NBYTES+1). NBYTES=1 is legal: one START/WAIT_DONE per frame.

Optional Feature:
TX_HEADER_EN
- Defined: every frame starts with HDR_BYTE, sent via its own START/WAIT_DONE cycle before byte 0. A frame is then NBYTES+1 bytes, and the trigger-to-first-start latency is unchanged (the first o_data is HDR_BYTE).
- Not defined: there is no header and the frame is exactly NBYTES bytes. HDR_BYTE is unused.

Test Plan:
- i_acc=16'h1234, i_halt rises, bench pulses i_tx_done 20 cycles after each start -> o_tx_start pulses with o_data=8'h34, then 8'h12; one o_frame_done; o_busy low afterwards; exactly 2 starts total.
- i_halt held high for 500 cycles after the frame completes -> no further o_tx_start.
- Mid-frame, i_send rises, then i_halt falls and re-rises -> first trigger sets pending and a second full frame follows; the second trigger pulses o_drop once; 4 starts total.
- i_halt and i_send rise on the same clock with i_acc=16'hBEEF -> single frame 8'hEF, 8'hBE; o_drop stays 0.
- i_reset=0 asserted in WAIT_DONE after byte 0 -> all outputs 0 immediately. After release, a new halt rise with i_acc=16'h00FF sends 8'hFF, 8'h00.
- TX_HEADER_EN defined, i_acc=16'h1234 -> o_data sequence 8'hA5, 8'h34, 8'h12; 3 starts; o_frame_done after the 3rd done.
